baby_vga_timing: RTL and testbench

Raster timing generator for the baby VGA peripheral, directly upstream of the framebuffer pixel path. It runs a 1024x768@60 raster from the 64 MHz TinyQV clock, one clock per pixel. It supplies split column/row coordinates sized for a 32x16-cell framebuffer, together with active-low hsync/vsync, a blank flag and a sticky start-of-vblank interrupt.

---
 rtl/baby_vga_timing.sv | 104 ++++++++++
 tb/tb_baby_vga_timing.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/baby_vga_timing.sv
// Raster timing generator: 1024x768 active area, one pixel per clock, split cell/offset
// coordinates, active-low syncs, blank, and a sticky start-of-vblank interrupt.
module baby_vga_timing #(
  parameter int unsigned H_FP   = 24,
  parameter int unsigned H_SYNC = 136,
  parameter int unsigned H_BP   = 160,
  parameter int unsigned V_FP   = 3,
  parameter int unsigned V_SYNC = 6,
  parameter int unsigned V_BP   = 29
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cli,
  output logic [5:0] x_hi,
  output logic [4:0] x_lo,
  output logic [4:0] y_hi,
  output logic [5:0] y_lo,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       interrupt
);

  localparam int unsigned HTotal = 1024 + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = 768 + V_FP + V_SYNC + V_BP;

  localparam logic [5:0]  XHiLast = 6'(HTotal / 32 - 1);
  localparam logic [4:0]  YHiLast = 5'((VTotal - 1) / 48);
  localparam logic [5:0]  YLoLast = 6'((VTotal - 1) % 48);
  localparam logic [10:0] HsStart = 11'(1024 + H_FP);
  localparam logic [10:0] HsEnd   = 11'(1024 + H_FP + H_SYNC);
  localparam logic [9:0]  VsStart = 10'(768 + V_FP);
  localparam logic [9:0]  VsEnd   = 10'(768 + V_FP + V_SYNC);

  logic [5:0] x_hi_q, x_hi_d;
  logic [4:0] x_lo_q, x_lo_d;
  logic [4:0] y_hi_q, y_hi_d;
  logic [5:0] y_lo_q, y_lo_d;
  logic       irq_q, irq_d;

  logic [10:0] x;
  logic [9:0]  y;
  logic        line_end;
  logic        frame_end;
  logic        irq_set;

  // y = 48*y_hi + y_lo built from shifts only
  assign x = {x_hi_q, x_lo_q};
  assign y = ({5'b0, y_hi_q} << 5) + ({5'b0, y_hi_q} << 4) + {4'b0, y_lo_q};

  assign line_end  = (x_hi_q == XHiLast) && (x_lo_q == 5'd31);
  assign frame_end = (y_hi_q == YHiLast) && (y_lo_q == YLoLast);
  // The edge leaving the last pixel of line 767 lands on (0,768)
  assign irq_set   = line_end && (y == 10'd767);

  always_comb begin
    x_lo_d = x_lo_q + 5'd1;
    x_hi_d = x_hi_q;
    y_lo_d = y_lo_q;
    y_hi_d = y_hi_q;
    if (line_end) begin
      x_hi_d = '0;
      if (frame_end) begin
        y_lo_d = '0;
        y_hi_d = '0;
      end else if (y_lo_q == 6'd47) begin
        y_lo_d = '0;
        y_hi_d = y_hi_q + 5'd1;
      end else begin
        y_lo_d = y_lo_q + 6'd1;
      end
    end else if (x_lo_q == 5'd31) begin
      x_hi_d = x_hi_q + 6'd1;
    end
  end

  assign irq_d = irq_set | (irq_q & ~cli);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_hi_q <= '0;
      x_lo_q <= '0;
      y_hi_q <= '0;
      y_lo_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      x_hi_q <= x_hi_d;
      x_lo_q <= x_lo_d;
      y_hi_q <= y_hi_d;
      y_lo_q <= y_lo_d;
      irq_q  <= irq_d;
    end
  end

  assign x_hi      = x_hi_q;
  assign x_lo      = x_lo_q;
  assign y_hi      = y_hi_q;
  assign y_lo      = y_lo_q;
  assign blank     = x_hi_q[5] | (y_hi_q >= 5'd16);
  assign hsync     = ~((x >= HsStart) && (x < HsEnd));
  assign vsync     = ~((y >= VsStart) && (y < VsEnd));
  assign interrupt = irq_q;

endmodule

// File: tb/tb_baby_vga_timing.sv
// Scoreboarded bench for baby_vga_timing: a flat-coordinate raster model queues the expected
// outputs per clock, a monitor compares them, and an observer checks sync/interrupt timing.
module tb_baby_vga_timing;

  localparam int HT    = 1344;
  localparam int VT    = 806;
  localparam int HS0   = 1048;
  localparam int HS1   = 1184;
  localparam int VS0   = 771;
  localparam int VS1   = 777;
  localparam int Frame = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cli = 1'b0;
  logic [5:0] x_hi;
  logic [4:0] x_lo;
  logic [4:0] y_hi;
  logic [5:0] y_lo;
  logic       hsync, vsync, blank, interrupt;

  baby_vga_timing dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cli       (cli),
    .x_hi      (x_hi),
    .x_lo      (x_lo),
    .y_hi      (y_hi),
    .y_lo      (y_lo),
    .hsync     (hsync),
    .vsync     (vsync),
    .blank     (blank),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] x_hi;
    logic [4:0] x_lo;
    logic [4:0] y_hi;
    logic [5:0] y_lo;
    logic       hsync;
    logic       vsync;
    logic       blank;
    logic       interrupt;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: flat pixel/line position since reset plus the interrupt flag
  int mx = 0, my = 0;
  bit m_int = 1'b0;
  bit m_rst = 1'b1;

  function automatic obs_t expect_now();
    obs_t e;
    e.x_hi      = 6'(mx / 32);
    e.x_lo      = 5'(mx % 32);
    e.y_hi      = 5'(my / 48);
    e.y_lo      = 6'(my % 48);
    e.blank     = (mx >= 1024) || (my >= 768);
    e.hsync     = !(mx >= HS0 && mx < HS1);
    e.vsync     = !(my >= VS0 && my < VS1);
    e.interrupt = m_int;
    return e;
  endfunction

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  function automatic void check(string name, longint got, longint want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endfunction

  // One clock with cli driven; expected state after the edge goes on the scoreboard
  task automatic tick(input bit c);
    cli = c;
    @(posedge clk);
    if (!m_rst) begin
      mx++;
      if (mx == HT) begin
        mx = 0;
        my++;
        if (my == VT) my = 0;
      end
      if (mx == 0 && my == 768) m_int = 1'b1;
      else if (c) m_int = 1'b0;
    end
    exp_q.push_back(expect_now());
    #1;
  endtask

  // Reset takes effect immediately, so the pending expectation for this cycle is replaced
  task automatic set_rst(input bit active);
    rst_n = !active;
    m_rst = active;
    if (active) begin
      mx = 0;
      my = 0;
      m_int = 1'b0;
      if (exp_q.size() > 0) exp_q[exp_q.size()-1] = expect_now();
    end
  endtask

  task automatic run_to(input int tx, input int ty, input bit rnd);
    int n;
    n = ((ty * HT + tx) - (my * HT + mx) + Frame) % Frame;
    for (int i = 0; i < n; i++) tick(rnd ? ($urandom_range(0, 15) == 0) : 1'b0);
  endtask

  initial begin : monitor
    obs_t act;
    obs_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        act.x_hi      = x_hi;
        act.x_lo      = x_lo;
        act.y_hi      = y_hi;
        act.y_lo      = y_lo;
        act.hsync     = hsync;
        act.vsync     = vsync;
        act.blank     = blank;
        act.interrupt = interrupt;
        vectors++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL raster: got x=%0d/%0d y=%0d/%0d hs=%b vs=%b bl=%b irq=%b, want x=%0d/%0d y=%0d/%0d hs=%b vs=%b bl=%b irq=%b",
                   act.x_hi, act.x_lo, act.y_hi, act.y_lo, act.hsync, act.vsync, act.blank,
                   act.interrupt, e.x_hi, e.x_lo, e.y_hi, e.y_lo, e.hsync, e.vsync, e.blank,
                   e.interrupt);
          if (miscompares >= 50) finish_run();
        end
      end
    end
  end

  // Clock edges since the most recent reset release
  longint since = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) since <= 0;
    else since <= since + 1;
  end

  initial begin : timing_obs
    longint hs_fall = -1;
    longint vs_fall = -1;
    logic   hs_p = 1'b1, vs_p = 1'b1, irq_p = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hs_fall = -1;
        vs_fall = -1;
      end else begin
        if (interrupt && !irq_p) check("irq_latency", since % Frame, 768 * HT);
        if (hs_p && !hsync) begin
          check("hsync_start_x", {x_hi, x_lo}, HS0);
          if (hs_fall >= 0) check("hsync_period", since - hs_fall, HT);
          hs_fall = since;
        end
        if (!hs_p && hsync && hs_fall >= 0) check("hsync_width", since - hs_fall, HS1 - HS0);
        if (vs_p && !vsync) begin
          check("vsync_start_x", {x_hi, x_lo}, 0);
          vs_fall = since;
        end
        if (!vs_p && vsync && vs_fall >= 0)
          check("vsync_width", since - vs_fall, (VS1 - VS0) * HT);
      end
      hs_p  = hsync;
      vs_p  = vsync;
      irq_p = interrupt;
    end
  end

  initial begin : stim
    set_rst(1'b1);
    repeat (3) tick(1'b0);
    set_rst(1'b0);
    for (int i = 0; i < 150; i++) tick($urandom_range(0, 7) == 0);
    // Short reset in the middle of a line
    set_rst(1'b1);
    repeat (2) tick(1'b0);
    set_rst(1'b0);
    // Mid-frame reset at y=400 for three clocks
    run_to(0, 400, 1'b1);
    set_rst(1'b1);
    repeat (3) tick(1'b0);
    set_rst(1'b0);
    // First vblank: cli held high across the set edge
    run_to(HT - 10, 767, 1'b1);
    repeat (20) tick(1'b1);
    // Through the frame wrap and on to the second vblank with cli quiet
    run_to(0, 0, 1'b1);
    run_to(HT - 10, 767, 1'b1);
    repeat (10) tick(1'b0);
    repeat (1000) tick(1'b0);
    tick(1'b1);
    repeat (20) tick(1'b0);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) check("scoreboard_drain", exp_q.size(), 0);
    finish_run();
  end

endmodule
